// File: rtl/truth_table_sweeper.sv
// Sweeps a 4-input logic function through all 16 input vectors, samples f after a
// settle interval and scores the sampled truth table against EXPECTED.
module truth_table_sweeper #(
   parameter logic [15:0] EXPECTED      = 16'hB2C4,
   parameter int          SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        f,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [4:0]  fail_count,
   output logic [3:0]  first_fail_idx,
   output logic [15:0] captured
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [3:0] idx;
   logic [7:0] cnt;

   // idx is itself a register and is forced to 0 on every return to IDLE,
   // so the datapath inputs are registered and idle-low without a shadow copy.
   assign {a, b, c, d} = idx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         idx            <= 4'd0;
         cnt            <= 8'd0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_count     <= 5'd0;
         first_fail_idx <= 4'd0;
         captured       <= 16'd0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  idx            <= 4'd0;
                  cnt            <= 8'd0;
                  fail_count     <= 5'd0;
                  pass           <= 1'b0;
                  captured       <= 16'd0;
                  first_fail_idx <= 4'd0;
                  busy           <= 1'b1;
                  state          <= S_DRIVE;
               end
            end

            S_DRIVE: begin
               if (abort) begin
                  idx   <= 4'd0;
                  cnt   <= 8'd0;
                  pass  <= 1'b0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (cnt == SETTLE_LAST) begin
                  cnt   <= 8'd0;
                  state <= S_SAMPLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end

            S_SAMPLE: begin
               // An abort landing on the sample cycle discards that sample.
               if (abort) begin
                  idx   <= 4'd0;
                  cnt   <= 8'd0;
                  pass  <= 1'b0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  captured[idx] <= f;
                  if (f != EXPECTED[idx]) begin
                     fail_count <= fail_count + 5'd1;
                     if (fail_count == 5'd0) begin
                        first_fail_idx <= idx;
                     end
                  end
                  if (idx == 4'd15) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     idx   <= idx + 4'd1;
                     state <= S_DRIVE;
                  end
               end
            end

            S_DONE: begin
               pass  <= (fail_count == 5'd0);
               idx   <= 4'd0;
               state <= S_IDLE;
            end

            default: begin
               idx   <= 4'd0;
               cnt   <= 8'd0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: f is served from a per-sweep table and
// each sweep's expected result is derived from that table and the reference truth table.
module tb_truth_table_sweeper;

   localparam int PER = 3;  // SETTLE_CYCLES + 1

   logic        clk = 1'b0;
   logic        rst_n, start, abort, f;
   logic        a, b, c, d, busy, done, pass;
   logic [4:0]  fail_count;
   logic [3:0]  first_fail_idx;
   logic [15:0] captured;

   logic [15:0] ftab   = 16'h0000;
   logic [15:0] exp_tt = 16'hB2C4;

   always #5 clk = ~clk;

   assign f = ftab[{a, b, c, d}];

   truth_table_sweeper #(.EXPECTED(16'hB2C4), .SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f(f),
      .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .pass(pass),
      .fail_count(fail_count), .first_fail_idx(first_fail_idx), .captured(captured)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] cap;
      logic [4:0]  fc;
      logic [3:0]  ffi;
      logic        pass;
      int          accept;
   } exp_t;

   exp_t q[$];
   bit   pass_pending = 1'b0;
   logic pass_exp     = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {a, b, c, d, busy, done, pass, fail_count, first_fail_idx, captured}, 32'd0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT pulses done.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pass_pending) begin
            chk("pass", 32'(pass), 32'(pass_exp));
            pass_pending = 1'b0;
         end
         if (done === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               e = q.pop_front();
               chk("done_cycle", 32'(cyc - e.accept + 1), 32'(16 * PER + 1));
               chk("captured", 32'(captured), 32'(e.cap));
               chk("fail_count", 32'(fail_count), 32'(e.fc));
               if (e.fc != 0) chk("first_fail_idx", 32'(first_fail_idx), 32'(e.ffi));
               pass_exp     = e.pass;
               pass_pending = 1'b1;
            end
         end
      end
   end

   // Issue start for one sweep; when push is set, the expected outcome is queued.
   task automatic sweep_begin(input logic [15:0] tab, input bit abort_too, input bit push);
      exp_t e;
      @(negedge clk);
      ftab  = tab;
      start = 1'b1;
      abort = abort_too;
      if (push) begin
         e.cap = tab;
         e.fc  = 5'($countones(tab ^ exp_tt));
         e.ffi = 4'd0;
         for (int i = 15; i >= 0; i--) if (tab[i] != exp_tt[i]) e.ffi = i[3:0];
         e.pass   = (e.fc == 5'd0);
         e.accept = cyc + 1;
         q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   // Check the driven vector and busy for sweep cycles 1..n; optionally re-pulse start.
   task automatic track(input int n, input int restart_at);
      for (int k = 1; k <= n; k++) begin
         chk("abcd", 32'({a, b, c, d}), 32'((k - 1) / PER));
         chk("busy", 32'(busy), 32'd1);
         start = (k == restart_at);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 8 && (q.size() != 0 || pass_pending); i++) @(negedge clk);
      if (q.size() != 0 || pass_pending) begin
         chk("done_timeout", 32'(q.size()), 32'd0);
         q.delete();
         pass_pending = 1'b0;
      end
      chk("idle_abcd", 32'({a, b, c, d, busy}), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset_outputs");
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_all_zero("idle_after_reset");
      end

      // Correct function, stuck-at-0, single inverted index, start+abort together.
      sweep_begin(exp_tt, 1'b0, 1'b1); track(48, 0); wait_done();
      sweep_begin(16'h0000, 1'b0, 1'b1); track(48, 0); wait_done();
      sweep_begin(exp_tt ^ 16'h0200, 1'b0, 1'b1); track(48, 0); wait_done();
      sweep_begin(exp_tt, 1'b1, 1'b1); track(48, 0); wait_done();

      // Start re-pulsed while on index 4 must not disturb the sweep.
      sweep_begin(16'($urandom), 1'b0, 1'b1); track(48, 4 * PER + 1); wait_done();

      // Abort while on index 5 (stuck-at-0 table: only index 2 has mismatched so far).
      sweep_begin(16'h0000, 1'b0, 1'b0);
      track(5 * PER, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_abcd", 32'({a, b, c, d}), 32'd0);
      chk("abort_pass", 32'(pass), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_fail_count", 32'(fail_count), 32'd1);
      chk("abort_first_fail", 32'(first_fail_idx), 32'd2);
      chk("abort_captured", 32'(captured), 32'd0);
      repeat (60) @(negedge clk);
      chk("abort_stays_idle", 32'({a, b, c, d, busy, done}), 32'd0);

      // Reset while on index 10, then a full correct sweep.
      sweep_begin(16'($urandom), 1'b0, 1'b0);
      track(10 * PER, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk_all_zero("midsweep_reset");
      rst_n = 1'b1;
      sweep_begin(exp_tt, 1'b0, 1'b1); track(48, 0); wait_done();

      for (int r = 0; r < 3; r++) begin
         sweep_begin(16'($urandom), 1'b0, 1'b1); track(48, 0); wait_done();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
